decode_buffer: RTL and testbench
================================

# decode_buffer

Parametrised instruction buffer and multi-lane decoder between the IF/ID boundary and the rename unit. Fetched instructions are enqueued one per cycle into a circular FIFO of `DEPTH` entries. Up to `DEQ_WIDTH` of the oldest entries are presented each cycle as pre-decoded lanes, so rename can consume several instructions per cycle. The block supports pipeline flush, consumer back-pressure and speculative-flag propagation.

## Interface
- `DEPTH`, 8, number of buffer entries; power of two, ≥ 2.
- `DEQ_WIDTH`, 2, number of decode lanes; 1 ≤ `DEQ_WIDTH` ≤ `DEPTH`.
- `clk`  input  1  clock; one clock; all state updates on rising edge.
- `rst`  input  1  reset; synchronous, active-high.
- `flush`  input  1  discard all buffered entries.
- `enq_valid`  input  1  fetch presents an instruction.
- `enq_ready`  output  1  buffer can accept this cycle.
- `enq_pc`  input  32  PC of the enqueued instruction.
- `enq_inst`  input  32  raw instruction word.
- `enq_spec`  input  1  speculative flag.
- `deq_valid`  output  `DEQ_WIDTH`  per-lane valid; always contiguous from lane 0.
- `deq_ready`  input  1  consumer takes every valid lane this cycle.
- `deq_pc`, `deq_inst`  output  32·`DEQ_WIDTH`  per-lane PC and instruction; lane i at bits [32i+31:32i].
- `deq_rs1_arch`, `deq_rs2_arch`, `deq_rd_arch`  output  5·`DEQ_WIDTH`  architectural register indices.
- `deq_imm`  output  32·`DEQ_WIDTH`  selected, sign-extended immediate.
- `deq_regf_we`, `deq_spec`, `deq_illegal`  output  `DEQ_WIDTH`  per-lane flags.
- `count`  output  $clog2(`DEPTH`)+1  number of occupied entries.

## Operation
- **State:**
  - `head` and `tail` pointers, each $clog2(`DEPTH`) bits, wrapping modulo `DEPTH`.
  - `count` register.
  - Entry storage holding {pc, inst, spec} per entry.
- **Enqueue:**
  - `enq_ready = !rst && (count != DEPTH)`. It depends only on registered state, never on `deq_ready`.
  - On `enq_valid && enq_ready && !flush`: write the entry at `tail`, then `tail <= tail+1`.
- **Dequeue:**
  - `n_avail = min(count, DEQ_WIDTH)`.
  - `deq_valid[i] = (i < n_avail)`.
  - Lane i shows the entry at `head+i` (mod `DEPTH`).
  - On `deq_ready && !flush`: `head <= head + n_avail`.
  - `deq_ready` with `n_avail = 0` is a no-op.
- **Count update:** `count <= count + enq_fire − deq_fire_n`. Simultaneous enqueue and dequeue is legal at any occupancy below `DEPTH`.
- **Flush:**
  - Highest priority after `rst`.
  - Next cycle `head = tail = count = 0`.
  - A same-cycle enqueue is dropped and a same-cycle dequeue is not counted.
- **Per-lane decode** (combinational from stored word):
  - rs1 = inst[19:15], rs2 = inst[24:20], rd = inst[11:7].
  - Immediate by opcode:
    - lui, auipc: U-type.
    - jal: J-type.
    - jalr, load, op_imm: I-type.
    - br: B-type.
    - store: S-type.
    - op_reg: 0.
  - `deq_illegal = 1` for any opcode outside {lui, auipc, jal, jalr, br, load, store, op_imm, op_reg}; its immediate is 0.
  - `deq_regf_we = 0` for br, store, illegal, or rd == 0; otherwise 1.
  - `deq_spec` = stored flag.
- **Invalid lanes:** all fields of invalid lanes are driven 0.

## Timing
- **Reset** (cycle after `rst` sampled high):
  - `count = 0`, `head = tail = 0`, `deq_valid = 0`, all lane fields 0.
  - `enq_ready = 0` while `rst` is high and 1 the first cycle after.
- **Latency:** an instruction enqueued at edge N is visible on `deq_*` after edge N; there is no same-cycle bypass, so empty-to-valid takes one cycle.
- **Registered vs. combinational:** `count` and the pointers are registered. Lane outputs are combinational from registered storage only, with no path from `enq_*` or `deq_ready`.
- **Full:** `enq_ready` stays low even if `deq_ready` is high that cycle. It rises the cycle after a dequeue.
- **Wrap-around:** lane indices wrap across entry `DEPTH−1` to entry 0 seamlessly.
- **Reset mid-operation:** the buffer is fully cleared and all stored entries are lost.

## Test plan
- **Reset, then single enqueue** (DEPTH=8, DEQ_WIDTH=2): one enqueue of `addi x5,x0,-1` (0xFFF00293) at PC 0x1000 → next cycle `deq_valid = 2'b01`, lane0 rd=5, imm=0xFFFFFFFF, regf_we=1, count=1.
- **Fill to full:** 8 back-to-back enqueues with `deq_ready = 0` → `enq_ready` low after the 8th, count=8. A 9th `enq_valid` is not accepted. One `deq_ready` pulse → count=6 and `enq_ready` high the next cycle.
- **Wrap-around:** steady enqueue/dequeue for 20 instructions with incrementing PCs → lanes output PCs strictly in order with no gaps or duplicates across pointer wrap.
- **Flush with simultaneous enqueue and dequeue at count=5** → next cycle count=0, `deq_valid=0`; the instruction enqueued in the flush cycle never appears.
- **Decode coverage:**
  - `beq` → regf_we=0 and B-immediate.
  - `sw` → S-immediate.
  - `lui` 0x12345 → imm 0x12345000.
  - `add x0,…` → regf_we=0.
  - Opcode 0x0F → illegal=1, imm=0.
- **Speculative flag:** alternating `enq_spec` values → `deq_spec` matches per lane in FIFO order.

Source files
------------

// File: rtl/decode_buffer.sv
// decode_buffer: circular instruction buffer between fetch and rename.
// Accepts one instruction per cycle and presents up to DEQ_WIDTH of the
// oldest entries as pre-decoded lanes. Lane outputs depend only on
// registered storage and pointers, never on enq_* or deq_ready.
module decode_buffer #(
  parameter int DEPTH     = 8,
  parameter int DEQ_WIDTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [31:0]                enq_pc,
  input  logic [31:0]                enq_inst,
  input  logic                       enq_spec,
  output logic [DEQ_WIDTH-1:0]       deq_valid,
  input  logic                       deq_ready,
  output logic [32*DEQ_WIDTH-1:0]    deq_pc,
  output logic [32*DEQ_WIDTH-1:0]    deq_inst,
  output logic [5*DEQ_WIDTH-1:0]     deq_rs1_arch,
  output logic [5*DEQ_WIDTH-1:0]     deq_rs2_arch,
  output logic [5*DEQ_WIDTH-1:0]     deq_rd_arch,
  output logic [32*DEQ_WIDTH-1:0]    deq_imm,
  output logic [DEQ_WIDTH-1:0]       deq_regf_we,
  output logic [DEQ_WIDTH-1:0]       deq_spec,
  output logic [DEQ_WIDTH-1:0]       deq_illegal,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BR     = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_OP_REG = 7'b0110011;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] n_avail;
  logic [CNT_W-1:0] deq_n;
  logic             enq_fire;

  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] inst_mem [DEPTH];
  logic        spec_mem [DEPTH];

  // True for the nine opcodes the rename stage understands.
  function automatic logic legal_op(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR,
      OP_LOAD, OP_STORE, OP_OP_IMM, OP_OP_REG: legal_op = 1'b1;
      default:                                 legal_op = 1'b0;
    endcase
  endfunction

  // Immediate selection and sign extension by instruction format.
  function automatic logic signed [31:0] imm_of(input logic [31:0] w);
    case (w[6:0])
      OP_LUI, OP_AUIPC:
        imm_of = signed'({w[31:12], 12'b0});
      OP_JAL:
        imm_of = signed'({{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0});
      OP_JALR, OP_LOAD, OP_OP_IMM:
        imm_of = signed'({{21{w[31]}}, w[30:20]});
      OP_BR:
        imm_of = signed'({{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0});
      OP_STORE:
        imm_of = signed'({{21{w[31]}}, w[30:25], w[11:7]});
      default:
        imm_of = '0;
    endcase
  endfunction

  // Register-file write enable: legal writers with a nonzero destination.
  function automatic logic writes_rf(input logic [31:0] w);
    writes_rf = legal_op(w[6:0]) && (w[6:0] != OP_BR) &&
                (w[6:0] != OP_STORE) && (w[11:7] != 5'd0);
  endfunction

  // enq_ready looks only at rst and registered occupancy, so a full buffer
  // never accepts even when the consumer drains in the same cycle.
  assign enq_ready = !rst && (count != CNT_W'(DEPTH));
  assign enq_fire  = enq_valid && enq_ready && !flush;
  assign n_avail   = (count < CNT_W'(DEQ_WIDTH)) ? count : CNT_W'(DEQ_WIDTH);
  assign deq_n     = (deq_ready && !flush) ? n_avail : '0;

  // Pointer and occupancy update; rst beats flush, flush beats traffic.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq_fire) begin
        tail <= tail + PTR_W'(1);
      end
      head  <= head + deq_n[PTR_W-1:0];
      count <= count + CNT_W'(enq_fire) - deq_n;
    end
  end

  // Entry storage write at tail; contents are meaningful only while occupied.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      pc_mem[tail]   <= enq_pc;
      inst_mem[tail] <= enq_inst;
      spec_mem[tail] <= enq_spec;
    end
  end

  // Lane read-out and decode from the oldest entries; invalid lanes drive zero.
  always_comb begin
    deq_valid    = '0;
    deq_pc       = '0;
    deq_inst     = '0;
    deq_rs1_arch = '0;
    deq_rs2_arch = '0;
    deq_rd_arch  = '0;
    deq_imm      = '0;
    deq_regf_we  = '0;
    deq_spec     = '0;
    deq_illegal  = '0;
    for (int i = 0; i < DEQ_WIDTH; i++) begin
      if (CNT_W'(i) < n_avail) begin
        deq_valid[i]          = 1'b1;
        deq_pc[32*i +: 32]    = pc_mem[head + PTR_W'(i)];
        deq_inst[32*i +: 32]  = inst_mem[head + PTR_W'(i)];
        deq_rs1_arch[5*i +: 5] = inst_mem[head + PTR_W'(i)][19:15];
        deq_rs2_arch[5*i +: 5] = inst_mem[head + PTR_W'(i)][24:20];
        deq_rd_arch[5*i +: 5]  = inst_mem[head + PTR_W'(i)][11:7];
        deq_imm[32*i +: 32]   = imm_of(inst_mem[head + PTR_W'(i)]);
        deq_regf_we[i]        = writes_rf(inst_mem[head + PTR_W'(i)]);
        deq_spec[i]           = spec_mem[head + PTR_W'(i)];
        deq_illegal[i]        = !legal_op(inst_mem[head + PTR_W'(i)][6:0]);
      end
    end
  end

endmodule

// File: tb/tb_decode_buffer.sv
// Directed bench for decode_buffer (DEPTH=8, DEQ_WIDTH=2).
module tb_decode_buffer;

  localparam int DEPTH = 8;
  localparam int DW    = 2;

  logic              clk = 1'b0;
  logic              rst, flush, enq_valid, enq_ready, enq_spec, deq_ready;
  logic [31:0]       enq_pc, enq_inst;
  logic [DW-1:0]     deq_valid, deq_regf_we, deq_spec, deq_illegal;
  logic [32*DW-1:0]  deq_pc, deq_inst, deq_imm;
  logic [5*DW-1:0]   deq_rs1_arch, deq_rs2_arch, deq_rd_arch;
  logic [3:0]        count;

  int n_cmp = 0;
  int n_bad = 0;
  int got, sent, cyc;

  decode_buffer #(.DEPTH(DEPTH), .DEQ_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_pc(enq_pc), .enq_inst(enq_inst), .enq_spec(enq_spec),
    .deq_valid(deq_valid), .deq_ready(deq_ready),
    .deq_pc(deq_pc), .deq_inst(deq_inst),
    .deq_rs1_arch(deq_rs1_arch), .deq_rs2_arch(deq_rs2_arch),
    .deq_rd_arch(deq_rd_arch), .deq_imm(deq_imm),
    .deq_regf_we(deq_regf_we), .deq_spec(deq_spec),
    .deq_illegal(deq_illegal), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [31:0] pc, input logic [31:0] inst, input logic spec);
    enq_valid = 1'b1;
    enq_pc    = pc;
    enq_inst  = inst;
    enq_spec  = spec;
    step();
    enq_valid = 1'b0;
  endtask

  task automatic deq();
    deq_ready = 1'b1;
    step();
    deq_ready = 1'b0;
  endtask

  function automatic logic [31:0] pc_l(input int i);
    return deq_pc[32*i +: 32];
  endfunction
  function automatic logic [31:0] inst_l(input int i);
    return deq_inst[32*i +: 32];
  endfunction
  function automatic logic [31:0] imm_l(input int i);
    return deq_imm[32*i +: 32];
  endfunction
  function automatic logic [31:0] rs1_l(input int i);
    return 32'(deq_rs1_arch[5*i +: 5]);
  endfunction
  function automatic logic [31:0] rs2_l(input int i);
    return 32'(deq_rs2_arch[5*i +: 5]);
  endfunction
  function automatic logic [31:0] rd_l(input int i);
    return 32'(deq_rd_arch[5*i +: 5]);
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
    enq_pc = '0; enq_inst = '0; enq_spec = 1'b0;

    // Reset state
    step(); step();
    chk("rst_enq_ready", 32'(enq_ready), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_deq_valid", 32'(deq_valid), 32'd0);
    chk("rst_lane0_pc", pc_l(0), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_enq_ready", 32'(enq_ready), 32'd1);

    // Single enqueue: addi x5,x0,-1
    enq(32'h1000, 32'hFFF00293, 1'b0);
    chk("single_valid", 32'(deq_valid), 32'b01);
    chk("single_pc", pc_l(0), 32'h1000);
    chk("single_rd", rd_l(0), 32'd5);
    chk("single_imm", imm_l(0), 32'hFFFFFFFF);
    chk("single_we", 32'(deq_regf_we), 32'b01);
    chk("single_count", 32'(count), 32'd1);
    chk("single_lane1_pc_zero", pc_l(1), 32'd0);
    chk("single_lane1_inst_zero", inst_l(1), 32'd0);
    deq();
    chk("single_drained", 32'(count), 32'd0);

    // Fill to full
    for (int k = 0; k < DEPTH; k++) enq(32'h2000 + 32'(4*k), 32'h00100093, 1'b0);
    chk("full_count", 32'(count), 32'd8);
    chk("full_enq_ready", 32'(enq_ready), 32'd0);
    chk("full_lane0_pc", pc_l(0), 32'h2000);
    chk("full_lane1_pc", pc_l(1), 32'h2004);
    enq_valid = 1'b1; enq_pc = 32'h2020;
    step();
    chk("ninth_rejected_count", 32'(count), 32'd8);
    deq_ready = 1'b1;
    step();
    enq_valid = 1'b0; deq_ready = 1'b0;
    chk("full_deq_count", 32'(count), 32'd6);
    chk("full_deq_enq_ready", 32'(enq_ready), 32'd1);
    chk("full_deq_lane0_pc", pc_l(0), 32'h2008);
    deq(); deq(); deq();
    chk("full_drained", 32'(count), 32'd0);

    // Wrap-around streaming of 20 instructions
    got = 0; sent = 0; cyc = 0;
    deq_ready = 1'b1;
    while (got < 20 && cyc < 100) begin
      for (int i = 0; i < DW; i++) begin
        if (deq_valid[i]) begin
          chk("wrap_pc", pc_l(i), 32'h3000 + 32'(4*got));
          got++;
        end
      end
      if (sent < 20 && enq_ready) begin
        enq_valid = 1'b1;
        enq_pc    = 32'h3000 + 32'(4*sent);
        enq_inst  = 32'h00000013;
        sent++;
      end else begin
        enq_valid = 1'b0;
      end
      step();
      cyc++;
    end
    enq_valid = 1'b0; deq_ready = 1'b0;
    chk("wrap_received", 32'(got), 32'd20);
    chk("wrap_count", 32'(count), 32'd0);

    // Flush with simultaneous enqueue and dequeue at count=5
    for (int k = 0; k < 5; k++) enq(32'h4000 + 32'(4*k), 32'h00000013, 1'b0);
    chk("pre_flush_count", 32'(count), 32'd5);
    flush = 1'b1; deq_ready = 1'b1; enq_valid = 1'b1; enq_pc = 32'h4BAD;
    step();
    flush = 1'b0; deq_ready = 1'b0; enq_valid = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(deq_valid), 32'd0);
    enq(32'h5000, 32'h00000013, 1'b0);
    chk("post_flush_valid", 32'(deq_valid), 32'b01);
    chk("post_flush_pc", pc_l(0), 32'h5000);
    chk("post_flush_count", 32'(count), 32'd1);
    deq();

    // Decode: beq x1,x2,-4 and sw x5,8(x2)
    enq(32'h6000, 32'hFE208EE3, 1'b0);
    enq(32'h6004, 32'h00512423, 1'b0);
    chk("beq_imm", imm_l(0), 32'hFFFFFFFC);
    chk("beq_rs1", rs1_l(0), 32'd1);
    chk("beq_rs2", rs2_l(0), 32'd2);
    chk("sw_imm", imm_l(1), 32'd8);
    chk("sw_rs1", rs1_l(1), 32'd2);
    chk("sw_rs2", rs2_l(1), 32'd5);
    chk("beq_sw_we", 32'(deq_regf_we), 32'b00);
    chk("beq_sw_illegal", 32'(deq_illegal), 32'b00);
    deq();
    // lui x10,0x12345 and add x0,x1,x2
    enq(32'h6008, 32'h12345537, 1'b0);
    enq(32'h600C, 32'h00208033, 1'b0);
    chk("lui_imm", imm_l(0), 32'h12345000);
    chk("lui_rd", rd_l(0), 32'd10);
    chk("add_imm", imm_l(1), 32'd0);
    chk("lui_add_we", 32'(deq_regf_we), 32'b01);
    deq();
    // jal x1,8 and illegal opcode 0x0F with rd=1
    enq(32'h6010, 32'h008000EF, 1'b0);
    enq(32'h6014, 32'h0FF0008F, 1'b0);
    chk("jal_imm", imm_l(0), 32'd8);
    chk("illegal_imm", imm_l(1), 32'd0);
    chk("jal_ill_illegal", 32'(deq_illegal), 32'b10);
    chk("jal_ill_we", 32'(deq_regf_we), 32'b01);
    chk("illegal_inst", inst_l(1), 32'h0FF0008F);
    deq();

    // Speculative flag propagation in FIFO order
    enq(32'h7000, 32'h00000013, 1'b1);
    enq(32'h7004, 32'h00000013, 1'b0);
    enq(32'h7008, 32'h00000013, 1'b1);
    enq(32'h700C, 32'h00000013, 1'b0);
    enq(32'h7010, 32'h00000013, 1'b1);
    chk("spec_pair0", 32'(deq_spec), 32'b01);
    deq();
    chk("spec_pair1", 32'(deq_spec), 32'b01);
    chk("spec_pair1_pc", pc_l(0), 32'h7008);
    deq();
    chk("spec_last", 32'(deq_spec), 32'b01);
    chk("spec_last_valid", 32'(deq_valid), 32'b01);
    deq();

    // Reset mid-operation
    for (int k = 0; k < 3; k++) enq(32'h8000 + 32'(4*k), 32'h00000013, 1'b1);
    rst = 1'b1;
    step();
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_valid", 32'(deq_valid), 32'd0);
    chk("midrst_enq_ready", 32'(enq_ready), 32'd0);
    chk("midrst_spec", 32'(deq_spec), 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst_release_ready", 32'(enq_ready), 32'd1);
    step();
    chk("midrst_stays_empty", 32'(count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
